// File: rtl/intt_if.sv
// Coefficient-array handshake between the inverse-NTT block and its host.
interface intt_if;
  logic        enable;
  logic [15:0] in  [256];
  logic [15:0] out [256];
  logic        valid;

  modport master (output enable, in, input out, valid);
  modport slave  (input enable, in, output out, valid);
endinterface

// File: rtl/intt.sv
// Kyber768 inverse NTT: Gentleman-Sande butterflies, one per cycle, over a
// 256x12 register array, then a per-coefficient scale by 128^-1 mod q.
module intt (
  input  logic   clk,
  input  logic   rst_n,
  intt_if.slave  bus
);

  localparam logic [12:0] Q         = 13'd3329;
  localparam int unsigned N         = 256;
  localparam logic [11:0] F_SCALE   = 12'd3303;
  localparam logic [12:0] BARRETT_M = 13'd5039;  // floor(2^24 / q)

  typedef enum logic [1:0] {S_IDLE, S_BFLY, S_SCALE, S_DONE} state_t;

  state_t      r_state, w_state_nxt;
  logic [11:0] r_coef [N];
  logic [7:0]  r_j, w_j_nxt;
  logic [7:0]  r_len, w_len_nxt;
  logic [8:0]  r_start, w_start_nxt;
  logic [6:0]  r_k, w_k_nxt;
  logic        r_valid;

  logic [11:0] w_zeta_rom [128];
  logic [11:0] w_zeta, w_a, w_b, w_s;
  logic [11:0] w_sum, w_prod, w_scaled;
  logic [7:0]  w_idx_b;
  logic [8:0]  w_step;
  logic        w_grp_end;

  function automatic logic [11:0] zeta_of(input int unsigned idx);
    int unsigned rev;
    int unsigned p;
    rev = 0;
    for (int unsigned b = 0; b < 7; b++)
      if (((idx >> b) & 1) != 0) rev = rev | (1 << (6 - b));
    p = 1;
    for (int unsigned e = 0; e < rev; e++) p = (p * 17) % 3329;
    return 12'(p);
  endfunction

  function automatic logic [11:0] mod_add(input logic [11:0] a, input logic [11:0] b);
    logic [12:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= Q) s = s - Q;
    return 12'(s);
  endfunction

  // Returns (b - a) mod q.
  function automatic logic [11:0] mod_sub(input logic [11:0] a, input logic [11:0] b);
    logic [12:0] d;
    d = {1'b0, b} - {1'b0, a};
    if (d[12]) d = d + Q;
    return 12'(d);
  endfunction

  // Barrett estimate undershoots the true quotient by at most 2.
  function automatic logic [11:0] mod_mul(input logic [11:0] a, input logic [11:0] b);
    logic [23:0] p;
    logic [36:0] t;
    logic [12:0] qh;
    logic [24:0] rem;
    p   = 24'(a) * 24'(b);
    t   = 37'(p) * 37'(BARRETT_M);
    qh  = 13'(t >> 24);
    rem = 25'(p) - 25'(qh) * 25'(Q);
    if (rem >= 25'(Q)) rem = rem - 25'(Q);
    if (rem >= 25'(Q)) rem = rem - 25'(Q);
    return 12'(rem);
  endfunction

  function automatic logic [11:0] cap_reduce(input logic [11:0] x);
    if ({1'b0, x} >= Q) return x - 12'(Q);
    return x;
  endfunction

  for (genvar g = 0; g < 128; g++) begin : g_zeta
    assign w_zeta_rom[g] = zeta_of(g);
  end

  assign w_zeta    = w_zeta_rom[r_k];
  assign w_idx_b   = r_j + r_len;
  assign w_a       = r_coef[r_j];
  assign w_b       = r_coef[w_idx_b];
  assign w_s       = r_coef[r_start[7:0]];
  assign w_sum     = mod_add(w_a, w_b);
  assign w_prod    = mod_mul(w_zeta, mod_sub(w_a, w_b));
  assign w_scaled  = mod_mul(w_s, F_SCALE);
  assign w_step    = r_start + {r_len, 1'b0};
  assign w_grp_end = ({1'b0, r_j} + 9'd1) == (r_start + {1'b0, r_len});

  always_comb begin
    w_state_nxt = r_state;
    w_j_nxt     = r_j;
    w_len_nxt   = r_len;
    w_start_nxt = r_start;
    w_k_nxt     = r_k;
    case (r_state)
      S_IDLE: begin
        if (bus.enable) begin
          w_state_nxt = S_BFLY;
          w_k_nxt     = 7'd127;
          w_len_nxt   = 8'd2;
          w_start_nxt = '0;
          w_j_nxt     = '0;
        end
      end
      S_BFLY: begin
        if (!w_grp_end) begin
          w_j_nxt = r_j + 8'd1;
        end else begin
          w_k_nxt = r_k - 7'd1;
          if (w_step == 9'd256) begin
            w_start_nxt = '0;
            w_j_nxt     = '0;
            if (r_len == 8'd128) w_state_nxt = S_SCALE;
            else                 w_len_nxt   = {r_len[6:0], 1'b0};
          end else begin
            w_start_nxt = w_step;
            w_j_nxt     = w_step[7:0];
          end
        end
      end
      S_SCALE: begin
        // r_start walks 0..256; the index-256 edge writes nothing so valid
        // rises one edge after the last scaled coefficient lands.
        if (r_start == 9'd256) begin
          w_state_nxt = S_DONE;
          w_start_nxt = '0;
        end else begin
          w_start_nxt = r_start + 9'd1;
        end
      end
      S_DONE: begin
        if (!bus.enable) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_j     <= '0;
      r_len   <= '0;
      r_start <= '0;
      r_k     <= '0;
      r_valid <= 1'b0;
      for (int unsigned i = 0; i < N; i++) r_coef[8'(i)] <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_j     <= w_j_nxt;
      r_len   <= w_len_nxt;
      r_start <= w_start_nxt;
      r_k     <= w_k_nxt;
      r_valid <= (w_state_nxt == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (bus.enable)
            for (int unsigned i = 0; i < N; i++)
              r_coef[8'(i)] <= cap_reduce(12'(bus.in[i]));
        end
        S_BFLY: begin
          r_coef[r_j]     <= w_sum;
          r_coef[w_idx_b] <= w_prod;
        end
        S_SCALE: begin
          if (!r_start[8]) r_coef[r_start[7:0]] <= w_scaled;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < N; i++) bus.out[i] = {4'b0000, r_coef[8'(i)]};
  end

  assign bus.valid = r_valid;

endmodule

// File: tb/tb_intt.sv
// Directed bench for intt: hand-computed vectors plus an FIPS 203 NTT^-1 reference.
module tb_intt;
  localparam int Q = 3329;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  intt_if bus ();
  intt dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks   = 0;
  int failures = 0;
  int vin  [256];
  int vexp [256];
  int zt   [128];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int zeta_ref(input int i);
    int rev = 0;
    int p = 1;
    for (int b = 0; b < 7; b++)
      if (i[b]) rev = rev | (1 << (6 - b));
    for (int e = 0; e < rev; e++) p = (p * 17) % Q;
    return p;
  endfunction

  function automatic void build_expected();
    int f [256];
    int k = 127;
    int t;
    int z;
    for (int i = 0; i < 256; i++) begin
      f[i] = vin[i] & 'hfff;
      if (f[i] >= Q) f[i] = f[i] - Q;
    end
    for (int len = 2; len <= 128; len = len * 2)
      for (int st = 0; st < 256; st = st + 2 * len) begin
        z = zt[k];
        k--;
        for (int j = st; j < st + len; j++) begin
          t = f[j];
          f[j] = (t + f[j + len]) % Q;
          f[j + len] = (z * ((f[j + len] - t + Q) % Q)) % Q;
        end
      end
    for (int i = 0; i < 256; i++) vexp[i] = (f[i] * 3303) % Q;
  endfunction

  task automatic check_out(input string tag);
    int bad = -1;
    int mx = 0;
    for (int i = 0; i < 256; i++) begin
      if (int'(bus.out[i]) > mx) mx = int'(bus.out[i]);
      if (bad < 0 && bus.out[i] !== 16'(vexp[i])) bad = i;
    end
    if (bad < 0) check(tag, 32'(bus.out[0]), vexp[0]);
    else         check($sformatf("%s[%0d]", tag, bad), 32'(bus.out[bad]), vexp[bad]);
    check({tag, "_range"}, 32'(mx < Q), 1);
  endtask

  task automatic run(input string tag, input bit toggle);
    int lat = 0;
    @(negedge clk);
    for (int i = 0; i < 256; i++) bus.in[i] = 16'(vin[i]);
    bus.enable = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 256; i++) bus.in[i] = 16'($urandom);
    while (bus.valid !== 1'b1 && lat < 1300) begin
      if (toggle) bus.enable = lat[1];
      @(posedge clk); #1;
      lat++;
    end
    bus.enable = 1'b1;
    check({tag, "_latency"}, lat, 1153);
    check_out(tag);
  endtask

  task automatic stop(input string tag);
    @(negedge clk);
    bus.enable = 1'b0;
    @(posedge clk); #1;
    check({tag, "_valid_drop"}, 32'(bus.valid), 0);
  endtask

  initial begin
    for (int k = 0; k < 128; k++) zt[k] = zeta_ref(k);
    rst_n = 1'b0;
    bus.enable = 1'b0;
    for (int i = 0; i < 256; i++) bus.in[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(bus.valid), 0);
    vexp = '{default: 0};
    check_out("rst_out");
    @(negedge clk) rst_n = 1'b1;

    // NTT of the constant 1: pairs (1,0) -> out[0]=1
    for (int i = 0; i < 256; i++) vin[i] = (i % 2 == 0) ? 1 : 0;
    for (int i = 0; i < 256; i++) vexp[i] = (i == 0) ? 1 : 0;
    run("ntt_one", 1'b0);
    repeat (6) @(posedge clk);
    #1;
    check("hold_valid", 32'(bus.valid), 1);
    check_out("hold_out");
    stop("ntt_one");

    // 0x0FFF captures as 766; high nibble of odd entries ignored
    for (int i = 0; i < 256; i++) vin[i] = (i % 2 == 0) ? 'h0fff : 'ha000;
    for (int i = 0; i < 256; i++) vexp[i] = (i == 0) ? 766 : 0;
    run("ntt_const", 1'b0);
    stop("ntt_const");

    vin  = '{default: 0};
    vexp = '{default: 0};
    run("zero", 1'b0);
    stop("zero");

    vin = '{default: 3328};
    build_expected();
    run("max", 1'b0);
    stop("max");

    for (int i = 0; i < 256; i++) vin[i] = 3329 + (i * 3) % 767 + ((i % 16) << 12);
    build_expected();
    run("over", 1'b0);
    stop("over");

    for (int i = 0; i < 256; i++) vin[i] = int'($urandom_range(0, 3328));
    build_expected();
    run("rand0", 1'b0);
    stop("rand0");

    for (int i = 0; i < 256; i++) vin[i] = int'($urandom_range(0, 3328));
    build_expected();
    run("toggle", 1'b1);
    stop("toggle");

    // reset in the middle of the butterfly phase
    for (int i = 0; i < 256; i++) vin[i] = int'($urandom_range(0, 4095));
    @(negedge clk);
    for (int i = 0; i < 256; i++) bus.in[i] = 16'(vin[i]);
    bus.enable = 1'b1;
    @(posedge clk); #1;
    bus.enable = 1'b0;
    repeat (499) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_valid", 32'(bus.valid), 0);
    vexp = '{default: 0};
    check_out("midrst_out");
    @(negedge clk) rst_n = 1'b1;
    build_expected();
    run("after_rst", 1'b0);
    stop("after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
